// File: rtl/multicycle_control_if.sv
// Bus between the RV32I multi-cycle main control FSM and its datapath.
// The master modport is the controller side; the slave modport is the datapath/memory side.
interface multicycle_control_if #(
    parameter int INSTRET_W = 32
) ();
    logic [6:0]           opcode_i;
    logic                 branch_taken_i;
    logic                 mem_ready_i;
    logic                 halt_i;
    logic [2:0]           ALU_Op_o;
    logic                 IR_Write_o;
    logic                 PC_Write_o;
    logic [1:0]           PC_Src_o;
    logic                 I_or_D_o;
    logic                 Mem_Read_o;
    logic                 Mem_Write_o;
    logic                 Reg_Write_o;
    logic [1:0]           Mem_to_Reg_o;
    logic                 ALU_Src_B_o;
    logic                 halted_o;
    logic                 illegal_o;
    logic [INSTRET_W-1:0] instret_o;

    modport master (
        input  opcode_i, branch_taken_i, mem_ready_i, halt_i,
        output ALU_Op_o, IR_Write_o, PC_Write_o, PC_Src_o, I_or_D_o,
        output Mem_Read_o, Mem_Write_o, Reg_Write_o, Mem_to_Reg_o,
        output ALU_Src_B_o, halted_o, illegal_o, instret_o
    );

    modport slave (
        output opcode_i, branch_taken_i, mem_ready_i, halt_i,
        input  ALU_Op_o, IR_Write_o, PC_Write_o, PC_Src_o, I_or_D_o,
        input  Mem_Read_o, Mem_Write_o, Reg_Write_o, Mem_to_Reg_o,
        input  ALU_Src_B_o, halted_o, illegal_o, instret_o
    );
endinterface

// File: rtl/multicycle_control.sv
// Multi-cycle main control FSM for the RV32I core: fetch/decode/execute/memory/writeback sequencing.
// Optional feature macro ILLEGAL_TRAP_EN: illegal opcodes park in TRAP instead of retiring as a NOP.
module multicycle_control #(
    parameter int MEM_HANDSHAKE = 1,
    parameter int INSTRET_W     = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    multicycle_control_if.master  bus
);
    typedef enum logic [2:0] {
        S_FETCH      = 3'd0,
        S_DECODE     = 3'd1,
        S_EXECUTE    = 3'd2,
        S_MEM_ACCESS = 3'd3,
        S_WRITEBACK  = 3'd4,
        S_BRANCH     = 3'd5,
        S_JUMP       = 3'd6,
        S_TRAP       = 3'd7
    } state_t;

    typedef enum logic [3:0] {
        C_R    = 4'd0,
        C_I    = 4'd1,
        C_LW   = 4'd2,
        C_SW   = 4'd3,
        C_LUI  = 4'd4,
        C_BR   = 4'd5,
        C_JAL  = 4'd6,
        C_JALR = 4'd7,
        C_ILL  = 4'd8
    } cls_t;

    typedef struct packed {
        logic [2:0] alu_op;
        logic [1:0] pc_src;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic [1:0] mem_to_reg;
        logic       alu_src_b;
        logic       pc_write;
    } ctl_t;

    function automatic cls_t classify(input logic [6:0] opc);
        cls_t c;
        case (opc)
            7'b0110011: c = C_R;
            7'b0010011: c = C_I;
            7'b0000011: c = C_LW;
            7'b0100011: c = C_SW;
            7'b0110111: c = C_LUI;
            7'b1100011: c = C_BR;
            7'b1101111: c = C_JAL;
            7'b1100111: c = C_JALR;
            default:    c = C_ILL;
        endcase
        return c;
    endfunction

    // Moore control word of a state; evaluated on the next state so the word is registered.
    function automatic ctl_t moore(input state_t st, input cls_t cls, input logic halted);
        ctl_t c;
        c        = '0;
        c.alu_op = 3'b111;
        case (st)
            S_FETCH: c.mem_read = ~halted;
            S_EXECUTE: begin
                case (cls)
                    C_R:     c.alu_op = 3'b000;
                    C_I:     begin c.alu_op = 3'b001; c.alu_src_b = 1'b1; end
                    C_LW:    begin c.alu_op = 3'b001; c.alu_src_b = 1'b1; end
                    C_SW:    begin c.alu_op = 3'b000; c.alu_src_b = 1'b1; end
                    C_LUI:   begin c.alu_op = 3'b010; c.alu_src_b = 1'b1; end
                    default: c.alu_op = 3'b111;
                endcase
            end
            S_MEM_ACCESS: begin
                c.i_or_d    = 1'b1;
                c.mem_read  = (cls == C_LW);
                c.mem_write = (cls == C_SW);
            end
            S_WRITEBACK: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = (cls == C_LW) ? 2'b01 : 2'b00;
            end
            S_BRANCH: begin
                c.alu_op = 3'b011;
                c.pc_src = 2'b01;
            end
            S_JUMP: begin
                if (cls == C_JALR) begin
                    c.alu_op    = 3'b101;
                    c.alu_src_b = 1'b1;
                    c.pc_src    = 2'b11;
                end else begin
                    c.alu_op = 3'b100;
                    c.pc_src = 2'b10;
                end
                c.pc_write   = 1'b1;
                c.reg_write  = 1'b1;
                c.mem_to_reg = 2'b10;
            end
            S_DECODE, S_TRAP: c.alu_op = 3'b111;
            default:          c.alu_op = 3'b111;
        endcase
        return c;
    endfunction

    state_t               state_r, state_n;
    cls_t                 cls_r, cls_n, dec_cls_s;
    ctl_t                 ctl_r;
    logic                 halted_r, halted_n;
    logic                 retire_s;
    logic                 ready_eff_s;
    logic                 fetch_done_s;
    logic [INSTRET_W-1:0] instret_r;
`ifdef ILLEGAL_TRAP_EN
    logic                 illegal_r;
`endif

    assign ready_eff_s  = (MEM_HANDSHAKE != 0) ? bus.mem_ready_i : 1'b1;
    assign dec_cls_s    = classify(bus.opcode_i);
    assign fetch_done_s = (state_r == S_FETCH) && !halted_r && ready_eff_s;

    // Next-state, instruction-class capture, halt parking and retire detection.
    always_comb begin
        state_n  = state_r;
        cls_n    = cls_r;
        halted_n = halted_r;
        retire_s = 1'b0;
        case (state_r)
            S_FETCH: begin
                if (halted_r) begin
                    halted_n = bus.halt_i;
                end else if (ready_eff_s) begin
                    state_n = S_DECODE;
                end else begin
                    state_n = S_FETCH;
                end
            end
            S_DECODE: begin
                cls_n = dec_cls_s;
                case (dec_cls_s)
                    C_BR:         state_n = S_BRANCH;
                    C_JAL, C_JALR: state_n = S_JUMP;
                    C_ILL: begin
`ifdef ILLEGAL_TRAP_EN
                        state_n = S_TRAP;
`else
                        state_n  = S_FETCH;
                        retire_s = 1'b1;
                        halted_n = bus.halt_i;
`endif
                    end
                    default:      state_n = S_EXECUTE;
                endcase
            end
            S_EXECUTE: begin
                if (cls_r == C_LW || cls_r == C_SW) begin
                    state_n = S_MEM_ACCESS;
                end else begin
                    state_n = S_WRITEBACK;
                end
            end
            S_MEM_ACCESS: begin
                if (!ready_eff_s) begin
                    state_n = S_MEM_ACCESS;
                end else if (cls_r == C_LW) begin
                    state_n = S_WRITEBACK;
                end else begin
                    state_n  = S_FETCH;
                    retire_s = 1'b1;
                    halted_n = bus.halt_i;
                end
            end
            S_WRITEBACK, S_BRANCH, S_JUMP: begin
                // Instruction boundary: halt_i is only honoured here.
                state_n  = S_FETCH;
                retire_s = 1'b1;
                halted_n = bus.halt_i;
            end
            S_TRAP:  state_n = S_TRAP;
            default: state_n = S_FETCH;
        endcase
    end

    // FSM state, registered Moore control word, halt/illegal flags and retired-instruction counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= S_FETCH;
            cls_r     <= C_ILL;
            halted_r  <= 1'b0;
            ctl_r     <= moore(S_FETCH, C_ILL, 1'b0);
            instret_r <= '0;
`ifdef ILLEGAL_TRAP_EN
            illegal_r <= 1'b0;
`endif
        end else begin
            state_r  <= state_n;
            cls_r    <= cls_n;
            halted_r <= halted_n;
            ctl_r    <= moore(state_n, cls_n, halted_n);
            if (retire_s) begin
                instret_r <= instret_r + INSTRET_W'(1);
            end else begin
                instret_r <= instret_r;
            end
`ifdef ILLEGAL_TRAP_EN
            illegal_r <= (state_n == S_TRAP);
`endif
        end
    end

    // Enables and requests are forced low while reset is high so an aborted access drops at once.
    assign bus.IR_Write_o   = !reset && fetch_done_s;
    assign bus.PC_Write_o   = !reset && (fetch_done_s || ctl_r.pc_write ||
                                         ((state_r == S_BRANCH) && bus.branch_taken_i));
    assign bus.Mem_Read_o   = !reset && ctl_r.mem_read;
    assign bus.Mem_Write_o  = !reset && ctl_r.mem_write;
    assign bus.Reg_Write_o  = !reset && ctl_r.reg_write;
    assign bus.ALU_Op_o     = ctl_r.alu_op;
    assign bus.PC_Src_o     = ctl_r.pc_src;
    assign bus.I_or_D_o     = ctl_r.i_or_d;
    assign bus.Mem_to_Reg_o = ctl_r.mem_to_reg;
    assign bus.ALU_Src_B_o  = ctl_r.alu_src_b;
    assign bus.halted_o     = halted_r;
    assign bus.instret_o    = instret_r;
`ifdef ILLEGAL_TRAP_EN
    assign bus.illegal_o    = illegal_r;
`else
    assign bus.illegal_o    = 1'b0;
`endif
endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-cycle control words compared against hand-written patterns.
// A 4-bit retired-instruction counter keeps the wrap case short.
module tb_multicycle_control;
    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    logic [3:0] exp_ir = 4'd0;

    always #5 clk = ~clk;

    multicycle_control_if #(.INSTRET_W(4)) bus ();

    multicycle_control #(.MEM_HANDSHAKE(1), .INSTRET_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_LUI  = 7'b0110111;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_ILL  = 7'h7F;

    // {ALU_Op, IR_Write, PC_Write, PC_Src, I_or_D, Mem_Read, Mem_Write, Reg_Write, Mem_to_Reg, ALU_Src_B}
    localparam logic [13:0] P_IDLE  = {3'd7, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0};
    localparam logic [13:0] P_FDONE = {3'd7, 1'b1, 1'b1, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0};
    localparam logic [13:0] P_FWAIT = {3'd7, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0};
    localparam logic [13:0] P_EXR   = {3'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0};
    localparam logic [13:0] P_EXI   = {3'd1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1};
    localparam logic [13:0] P_EXSW  = {3'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1};
    localparam logic [13:0] P_EXLUI = {3'd2, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1};
    localparam logic [13:0] P_MLW   = {3'd7, 1'b0, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0};
    localparam logic [13:0] P_MSW   = {3'd7, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0};
    localparam logic [13:0] P_MRST  = {3'd7, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0};
    localparam logic [13:0] P_WBA   = {3'd7, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0};
    localparam logic [13:0] P_WBL   = {3'd7, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0};
    localparam logic [13:0] P_BRT   = {3'd3, 1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0};
    localparam logic [13:0] P_BRN   = {3'd3, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0};
    localparam logic [13:0] P_JALR  = {3'd5, 1'b0, 1'b1, 2'd3, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 1'b1};
    localparam logic [13:0] P_JAL   = {3'd4, 1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 1'b0};

    wire [13:0] obs = {bus.ALU_Op_o, bus.IR_Write_o, bus.PC_Write_o, bus.PC_Src_o, bus.I_or_D_o,
                       bus.Mem_Read_o, bus.Mem_Write_o, bus.Reg_Write_o, bus.Mem_to_Reg_o,
                       bus.ALU_Src_B_o};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One clock cycle: drive this cycle's inputs just after the edge, then compare the control word.
    task automatic step(input string tag, input logic rst, input logic [6:0] opc, input logic rdy,
                        input logic tk, input logic hlt, input logic [13:0] exp);
        @(posedge clk);
        #1;
        reset              = rst;
        bus.opcode_i       = opc;
        bus.mem_ready_i    = rdy;
        bus.branch_taken_i = tk;
        bus.halt_i         = hlt;
        #1;
        check_eq(tag, 32'(obs), 32'(exp));
    endtask

    task automatic fetch(input string tag, input logic [6:0] opc);
        step(tag, 1'b0, opc, 1'b1, 1'b0, 1'b0, P_FDONE);
        check_eq({tag, "_instret"}, 32'(bus.instret_o), 32'(exp_ir));
        check_eq({tag, "_halted"}, 32'(bus.halted_o), 32'd0);
    endtask

    initial begin
        bus.opcode_i       = 7'd0;
        bus.mem_ready_i    = 1'b1;
        bus.branch_taken_i = 1'b0;
        bus.halt_i         = 1'b0;

        step("reset", 1'b1, 7'd0, 1'b1, 1'b0, 1'b0, P_IDLE);
        check_eq("reset_instret", 32'(bus.instret_o), 32'd0);
        check_eq("reset_halted", 32'(bus.halted_o), 32'd0);
        check_eq("reset_illegal", 32'(bus.illegal_o), 32'd0);

        fetch("add_f", OP_R);
        step("add_d", 1'b0, OP_R, 1'b1, 1'b0, 1'b0, P_IDLE);
        step("add_ex", 1'b0, OP_R, 1'b1, 1'b0, 1'b0, P_EXR);
        step("add_wb", 1'b0, OP_R, 1'b1, 1'b0, 1'b0, P_WBA);
        check_eq("add_wb_instret", 32'(bus.instret_o), 32'd0);
        exp_ir++;

        fetch("lw_f", OP_LW);
        step("lw_d", 1'b0, OP_LW, 1'b1, 1'b0, 1'b0, P_IDLE);
        step("lw_ex", 1'b0, OP_LW, 1'b1, 1'b0, 1'b0, P_EXI);
        for (int i = 0; i < 3; i++) begin
            step("lw_mem_wait", 1'b0, OP_LW, 1'b0, 1'b0, 1'b0, P_MLW);
        end
        step("lw_mem_rdy", 1'b0, OP_LW, 1'b1, 1'b0, 1'b0, P_MLW);
        step("lw_wb", 1'b0, OP_LW, 1'b1, 1'b0, 1'b0, P_WBL);
        exp_ir++;

        fetch("beqt_f", OP_BR);
        step("beqt_d", 1'b0, OP_BR, 1'b1, 1'b0, 1'b0, P_IDLE);
        step("beqt_br", 1'b0, OP_BR, 1'b1, 1'b1, 1'b0, P_BRT);
        exp_ir++;

        fetch("beqn_f", OP_BR);
        step("beqn_d", 1'b0, OP_BR, 1'b1, 1'b0, 1'b0, P_IDLE);
        step("beqn_br", 1'b0, OP_BR, 1'b1, 1'b0, 1'b0, P_BRN);
        exp_ir++;

        fetch("jalr_f", OP_JALR);
        step("jalr_d", 1'b0, OP_JALR, 1'b1, 1'b0, 1'b0, P_IDLE);
        step("jalr_j", 1'b0, OP_JALR, 1'b1, 1'b0, 1'b0, P_JALR);
        exp_ir++;

        fetch("jal_f", OP_JAL);
        step("jal_d", 1'b0, OP_JAL, 1'b1, 1'b0, 1'b0, P_IDLE);
        step("jal_j", 1'b0, OP_JAL, 1'b1, 1'b0, 1'b0, P_JAL);
        exp_ir++;

        fetch("sw_f", OP_SW);
        step("sw_d", 1'b0, OP_SW, 1'b1, 1'b0, 1'b0, P_IDLE);
        step("sw_ex", 1'b0, OP_SW, 1'b1, 1'b0, 1'b0, P_EXSW);
        step("sw_mem", 1'b0, OP_SW, 1'b1, 1'b0, 1'b0, P_MSW);
        exp_ir++;

        fetch("lui_f", OP_LUI);
        step("lui_d", 1'b0, OP_LUI, 1'b1, 1'b0, 1'b0, P_IDLE);
        step("lui_ex", 1'b0, OP_LUI, 1'b1, 1'b0, 1'b0, P_EXLUI);
        step("lui_wb", 1'b0, OP_LUI, 1'b1, 1'b0, 1'b0, P_WBA);
        exp_ir++;

        step("addi_fwait", 1'b0, OP_I, 1'b0, 1'b0, 1'b0, P_FWAIT);
        fetch("addi_f", OP_I);
        step("addi_d", 1'b0, OP_I, 1'b1, 1'b0, 1'b0, P_IDLE);
        step("addi_ex", 1'b0, OP_I, 1'b1, 1'b0, 1'b0, P_EXI);
        step("addi_wb", 1'b0, OP_I, 1'b1, 1'b0, 1'b0, P_WBA);
        exp_ir++;

        fetch("ill_f", OP_ILL);
        step("ill_d", 1'b0, OP_ILL, 1'b1, 1'b0, 1'b0, P_IDLE);
`ifdef ILLEGAL_TRAP_EN
        step("trap_1", 1'b0, OP_ILL, 1'b1, 1'b0, 1'b0, P_IDLE);
        check_eq("trap_1_illegal", 32'(bus.illegal_o), 32'd1);
        step("trap_2", 1'b0, OP_R, 1'b1, 1'b0, 1'b0, P_IDLE);
        check_eq("trap_2_illegal", 32'(bus.illegal_o), 32'd1);
        check_eq("trap_2_instret", 32'(bus.instret_o), 32'(exp_ir));
        step("trap_rst", 1'b1, OP_R, 1'b1, 1'b0, 1'b0, P_IDLE);
        exp_ir = 4'd0;
`else
        check_eq("ill_illegal", 32'(bus.illegal_o), 32'd0);
        exp_ir++;
`endif

        fetch("hlw_f", OP_LW);
        step("hlw_d", 1'b0, OP_LW, 1'b1, 1'b0, 1'b1, P_IDLE);
        step("hlw_ex", 1'b0, OP_LW, 1'b1, 1'b0, 1'b1, P_EXI);
        step("hlw_mem", 1'b0, OP_LW, 1'b1, 1'b0, 1'b1, P_MLW);
        step("hlw_wb", 1'b0, OP_LW, 1'b1, 1'b0, 1'b1, P_WBL);
        exp_ir++;
        step("halt_park", 1'b0, OP_SW, 1'b1, 1'b0, 1'b1, P_IDLE);
        check_eq("halt_park_halted", 32'(bus.halted_o), 32'd1);
        check_eq("halt_park_instret", 32'(bus.instret_o), 32'(exp_ir));
        step("halt_hold", 1'b0, OP_SW, 1'b1, 1'b0, 1'b1, P_IDLE);
        step("halt_release", 1'b0, OP_SW, 1'b1, 1'b0, 1'b0, P_IDLE);
        check_eq("halt_release_halted", 32'(bus.halted_o), 32'd1);

        fetch("swr_f", OP_SW);
        step("swr_d", 1'b0, OP_SW, 1'b1, 1'b0, 1'b0, P_IDLE);
        step("swr_ex", 1'b0, OP_SW, 1'b1, 1'b0, 1'b0, P_EXSW);
        step("swr_mem_rst", 1'b1, OP_SW, 1'b0, 1'b0, 1'b0, P_MRST);
        exp_ir = 4'd0;

        for (int i = 0; i < 16; i++) begin
            fetch((i == 0) ? "after_rst_f" : "wrap_f", OP_BR);
            step("wrap_d", 1'b0, OP_BR, 1'b1, 1'b0, 1'b0, P_IDLE);
            step("wrap_br", 1'b0, OP_BR, 1'b1, 1'b0, 1'b0, P_BRN);
            exp_ir++;
        end
        fetch("wrap_zero_f", OP_R);
        check_eq("wrap_zero", 32'(bus.instret_o), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
